// File: rtl/multi_design_mux_pkg.sv
// Shared types and helpers for the multi-design IO pad mux.
package multi_design_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    RST,
    RUN
  } state_t;

  // Wide all-ones pattern; the top slices it down to its selector width.
  localparam logic [15:0] SEL_NONE = '1;

  // LSB position of a slot inside a flattened per-slot bus.
  function automatic int slice_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/mux_sync_edge.sv
// Two-flop synchroniser with an optional registered rising-edge pulse.
module mux_sync_edge #(
  parameter int WIDTH   = 1,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= '0;
      sync_q <= '0;
    end else begin
      meta   <= din;
      sync_q <= meta;
    end
  end

  assign sync = sync_q;

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] prev_q;
      logic [WIDTH-1:0] rise_q;

      // One-cycle pulse in the cycle after the synchronised level goes high.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= '0;
          rise_q <= '0;
        end else begin
          prev_q <= sync_q;
          rise_q <= sync_q & ~prev_q;
        end
      end

      assign rise = rise_q;
    end else begin : g_no_edge
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/multi_design_mux.sv
// Shares the IO pads among NUM_DESIGNS user macros with a safe
// drain / blank / auto-reset / connect handover on every reselection.
module multi_design_mux
  import multi_design_mux_pkg::*;
#(
  parameter int NUM_DESIGNS   = 8,
  parameter int IO_W          = 38,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int RESET_CYCLES  = 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_enb,
  input  logic                      i_mux_conf_clk,
  input  logic [SEL_W-1:0]          i_mux_sel,
  input  logic                      i_auto_reset_enb,
  input  logic [NUM_DESIGNS-1:0]    i_design_reset,
  input  logic [IO_W-1:0]           io_in,
  output logic [IO_W-1:0]           io_out,
  output logic [IO_W-1:0]           io_oeb,
  input  logic [NUM_DESIGNS*IO_W-1:0] d_io_out,
  input  logic [NUM_DESIGNS*IO_W-1:0] d_io_oeb,
  output logic [IO_W-1:0]           d_io_in,
  output logic [NUM_DESIGNS-1:0]    d_rst,
  output logic [NUM_DESIGNS-1:0]    d_ena,
  output logic [SEL_W-1:0]          o_active_sel,
  output logic                      o_busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W-1:0] NONE = SEL_NONE[SEL_W-1:0];

  state_t                   state, state_n;
  logic [SEL_W-1:0]         active, active_n;
  logic [SEL_W-1:0]         target, target_n;
  logic [SEL_W-1:0]         pending, pending_n;
  logic                     pend_valid, pend_valid_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [SEL_W-1:0]         sel_req;
  logic                     commit;
  logic                     conf_sync_unused;
  logic [NUM_DESIGNS-1:0]   rst_sync;
  logic [NUM_DESIGNS-1:0]   drst_rise_unused;

  mux_sync_edge #(.WIDTH(1), .EDGE_EN(1'b1)) u_conf_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_enb),
    .din   (i_mux_conf_clk),
    .sync  (conf_sync_unused),
    .rise  (commit)
  );

  mux_sync_edge #(.WIDTH(NUM_DESIGNS), .EDGE_EN(1'b0)) u_drst_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_enb),
    .din   (i_design_reset),
    .sync  (rst_sync),
    .rise  (drst_rise_unused)
  );

  // Out-of-range selections collapse to "none" so every comparison sees one encoding.
  assign sel_req = (int'(i_mux_sel) >= NUM_DESIGNS) ? NONE : i_mux_sel;

  // Handover state, selection registers and the shared phase counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_enb) begin
    if (!wb_rst_enb) begin
      state      <= IDLE;
      active     <= NONE;
      target     <= NONE;
      pending    <= NONE;
      pend_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      active     <= active_n;
      target     <= target_n;
      pending    <= pending_n;
      pend_valid <= pend_valid_n;
      cnt        <= cnt_n;
    end
  end

  // Next-state logic: fresh commits start a drain when settled, are queued while busy.
  always_comb begin
    state_n      = state;
    active_n     = active;
    target_n     = target;
    pending_n    = pending;
    pend_valid_n = pend_valid;
    cnt_n        = cnt;
    case (state)
      IDLE, RUN: begin
        pend_valid_n = 1'b0;
        if (commit && (sel_req != active)) begin
          target_n = sel_req;
          cnt_n    = CNT_W'(SETTLE_CYCLES);
          state_n  = DRAIN;
        end else if (pend_valid && (pending != active)) begin
          target_n = pending;
          cnt_n    = CNT_W'(SETTLE_CYCLES);
          state_n  = DRAIN;
        end
      end
      DRAIN: begin
        if (commit && (sel_req != target)) begin
          pending_n    = sel_req;
          pend_valid_n = 1'b1;
        end
        if (cnt == CNT_W'(1)) begin
          active_n = target;
          if (target == NONE) begin
            state_n = IDLE;
          end else if (!i_auto_reset_enb) begin
            cnt_n   = CNT_W'(RESET_CYCLES);
            state_n = RST;
          end else begin
            state_n = RUN;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      RST: begin
        if (commit && (sel_req != target)) begin
          pending_n    = sel_req;
          pend_valid_n = 1'b1;
        end
        if (cnt == CNT_W'(1)) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pad routing: blanked and every slot held in reset unless the active slot is running.
  always_comb begin
    io_out  = '0;
    io_oeb  = '1;
    d_io_in = '0;
    d_ena   = '0;
    d_rst   = '1;
    if (state == RUN) begin
      d_io_in = io_in;
      for (int k = 0; k < NUM_DESIGNS; k++) begin
        if (active == SEL_W'(k)) begin
          io_out   = d_io_out[slice_lsb(k, IO_W) +: IO_W];
          io_oeb   = d_io_oeb[slice_lsb(k, IO_W) +: IO_W];
          d_ena[k] = 1'b1;
          d_rst[k] = rst_sync[k];
        end
      end
    end
  end

  assign o_active_sel = active;
  assign o_busy       = (state == DRAIN) || (state == RST);

endmodule

// File: tb/tb_multi_design_mux.sv
// Scoreboard bench for multi_design_mux: each handover pushes its expected
// settled outputs, and a monitor pops one record whenever o_busy drops.
module tb_multi_design_mux;

  localparam int N  = 8;
  localparam int W  = 38;
  localparam int SW = 4;
  localparam logic [W-1:0] IO_IN_VAL = 38'h15_5555_1234;

  logic             wb_clk_i;
  logic             wb_rst_enb;
  logic             i_mux_conf_clk;
  logic [SW-1:0]    i_mux_sel;
  logic             i_auto_reset_enb;
  logic [N-1:0]     i_design_reset;
  logic [W-1:0]     io_in;
  logic [W-1:0]     io_out;
  logic [W-1:0]     io_oeb;
  logic [N*W-1:0]   d_io_out;
  logic [N*W-1:0]   d_io_oeb;
  logic [W-1:0]     d_io_in;
  logic [N-1:0]     d_rst;
  logic [N-1:0]     d_ena;
  logic [SW-1:0]    o_active_sel;
  logic             o_busy;

  typedef struct {
    int           busy_len;
    logic [3:0]   sel;
    logic [7:0]   ena;
    logic [7:0]   drst;
    logic [37:0]  out;
    logic [37:0]  oeb;
    logic [37:0]  din;
    bit           rebusy;
  } exp_t;

  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   busy_run;
  bit   rebusy_chk;

  multi_design_mux #(
    .NUM_DESIGNS(N), .IO_W(W), .SEL_W(SW), .SETTLE_CYCLES(16), .RESET_CYCLES(8)
  ) dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_enb       (wb_rst_enb),
    .i_mux_conf_clk   (i_mux_conf_clk),
    .i_mux_sel        (i_mux_sel),
    .i_auto_reset_enb (i_auto_reset_enb),
    .i_design_reset   (i_design_reset),
    .io_in            (io_in),
    .io_out           (io_out),
    .io_oeb           (io_oeb),
    .d_io_out         (d_io_out),
    .d_io_oeb         (d_io_oeb),
    .d_io_in          (d_io_in),
    .d_rst            (d_rst),
    .d_ena            (d_ena),
    .o_active_sel     (o_active_sel),
    .o_busy           (o_busy)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [37:0] pat_out(input int k);
    return 38'h15_0000_0000 | (38'(k + 1) * 38'h00_0101_0101);
  endfunction

  function automatic logic [37:0] pat_oeb(input int k);
    return 38'h2A_A000_0000 | 38'(k * 3 + 1);
  endfunction

  function automatic exp_t make_exp(input int busy, input logic [3:0] sel, input bit rebusy);
    exp_t e;
    e.busy_len = busy;
    e.sel      = sel;
    e.rebusy   = rebusy;
    if (sel == 4'hF) begin
      e.ena  = 8'h00;
      e.drst = 8'hFF;
      e.out  = '0;
      e.oeb  = '1;
      e.din  = '0;
    end else begin
      e.ena  = 8'(1) << sel;
      e.drst = ~e.ena;
      e.out  = pat_out(int'(sel));
      e.oeb  = pat_oeb(int'(sel));
      e.din  = IO_IN_VAL;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic auto_enb);
    @(posedge wb_clk_i); #2;
    i_mux_sel        = sel;
    i_auto_reset_enb = auto_enb;
    i_mux_conf_clk   = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #2;
    i_mux_conf_clk   = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge wb_clk_i);
      c++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL handover_timeout: %0d expectations left, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge wb_clk_i);
  endtask

  // Monitor: counts busy cycles and checks the settled outputs when busy drops.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_enb) begin
      busy_run   = 0;
      rebusy_chk = 1'b0;
    end else begin
      if (rebusy_chk) begin
        checkOutput("rebusy_after_one_cycle", 64'(o_busy), 64'd1);
        rebusy_chk = 1'b0;
      end
      if (o_busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_handover_len", 64'(busy_run), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("busy_len",     64'(busy_run),     64'(e.busy_len));
          checkOutput("active_sel",   64'(o_active_sel), 64'(e.sel));
          checkOutput("d_ena",        64'(d_ena),        64'(e.ena));
          checkOutput("d_rst",        64'(d_rst),        64'(e.drst));
          checkOutput("io_out",       64'(io_out),       64'(e.out));
          checkOutput("io_oeb",       64'(io_oeb),       64'(e.oeb));
          checkOutput("d_io_in",      64'(d_io_in),      64'(e.din));
          rebusy_chk = e.rebusy;
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    n_checks         = 0;
    n_fail           = 0;
    busy_run         = 0;
    rebusy_chk       = 1'b0;
    wb_rst_enb       = 1'b0;
    i_mux_conf_clk   = 1'b0;
    i_mux_sel        = '0;
    i_auto_reset_enb = 1'b0;
    i_design_reset   = '0;
    io_in            = IO_IN_VAL;
    for (int k = 0; k < N; k++) begin
      d_io_out[k*W +: W] = pat_out(k);
      d_io_oeb[k*W +: W] = pat_oeb(k);
    end

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("rst_io_out",  64'(io_out),       64'd0);
    checkOutput("rst_io_oeb",  64'(io_oeb),       64'h3F_FFFF_FFFF);
    checkOutput("rst_d_io_in", 64'(d_io_in),      64'd0);
    checkOutput("rst_d_rst",   64'(d_rst),        64'hFF);
    checkOutput("rst_d_ena",   64'(d_ena),        64'h00);
    checkOutput("rst_busy",    64'(o_busy),       64'd0);
    checkOutput("rst_sel",     64'(o_active_sel), 64'hF);
    #1;
    wb_rst_enb = 1'b1;

    // First selection with auto reset: 16 drain + 8 reset cycles
    sb.push_back(make_exp(24, 4'd2, 1'b0));
    applyStimulus(4'd2, 1'b0);
    waitDone(200);

    // Same slot again: ignored, busy never rises
    applyStimulus(4'd2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge wb_clk_i); #1;
      checkOutput("same_sel_busy", 64'(o_busy), 64'd0);
    end
    checkOutput("same_sel_active", 64'(o_active_sel), 64'd2);

    // Slot 5, then slot 7 committed during the drain toward 5
    sb.push_back(make_exp(24, 4'd5, 1'b1));
    sb.push_back(make_exp(24, 4'd7, 1'b0));
    applyStimulus(4'd5, 1'b0);
    repeat (6) @(posedge wb_clk_i);
    applyStimulus(4'd7, 1'b0);
    waitDone(300);

    // Out-of-range selection disconnects everything after the drain
    sb.push_back(make_exp(16, 4'hF, 1'b0));
    applyStimulus(4'hC, 1'b0);
    waitDone(200);

    // Auto reset disabled: RUN straight after the drain
    sb.push_back(make_exp(16, 4'd3, 1'b0));
    applyStimulus(4'd3, 1'b1);
    waitDone(200);

    // Manual reset of the running slot forces its reset without touching the pads
    @(posedge wb_clk_i); #2;
    i_design_reset = 8'h08;
    repeat (4) @(posedge wb_clk_i);
    #1;
    checkOutput("manual_d_rst",  64'(d_rst),  64'hFF);
    checkOutput("manual_io_out", 64'(io_out), 64'(pat_out(3)));
    checkOutput("manual_d_ena",  64'(d_ena),  64'h08);
    checkOutput("manual_busy",   64'(o_busy), 64'd0);
    #1;
    i_design_reset = 8'h00;
    repeat (4) @(posedge wb_clk_i);
    #1;
    checkOutput("manual_release_d_rst", 64'(d_rst), 64'hF7);

    // Asynchronous reset in the middle of the reset phase
    applyStimulus(4'd6, 1'b0);
    c = 0;
    while (o_active_sel !== 4'd6 && c < 100) begin
      @(negedge wb_clk_i);
      c++;
    end
    checkOutput("abort_reach_sel6", 64'(o_active_sel), 64'd6);
    repeat (4) @(posedge wb_clk_i);
    #1;
    checkOutput("abort_pre_busy", 64'(o_busy), 64'd1);
    wb_rst_enb = 1'b0;
    #1;
    checkOutput("abort_io_oeb", 64'(io_oeb),       64'h3F_FFFF_FFFF);
    checkOutput("abort_d_rst",  64'(d_rst),        64'hFF);
    checkOutput("abort_d_ena",  64'(d_ena),        64'h00);
    checkOutput("abort_busy",   64'(o_busy),       64'd0);
    checkOutput("abort_sel",    64'(o_active_sel), 64'hF);
    repeat (2) @(posedge wb_clk_i);
    #2;
    wb_rst_enb = 1'b1;
    repeat (5) @(posedge wb_clk_i);
    #1;
    checkOutput("post_abort_busy",   64'(o_busy),       64'd0);
    checkOutput("post_abort_sel",    64'(o_active_sel), 64'hF);
    checkOutput("post_abort_io_oeb", 64'(io_oeb),       64'h3F_FFFF_FFFF);

    // Normal handover still works after the abort
    sb.push_back(make_exp(24, 4'd1, 1'b0));
    applyStimulus(4'd1, 1'b0);
    waitDone(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
